// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_stage                                                     |
// | Description : MIPS write-back stage. Drives the register-file write port   |
// |               from MEM-stage results, waits for SRAM load data, aligns and |
// |               extends it, stalls upstream while a load is outstanding,     |
// |               and keeps a load watchdog and a retired-instruction count.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_stage #(
    parameter int MAX_WAIT   = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wen,
    input  logic [4:0]  mem_dst,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_ld_type,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_result,
    output logic        wb_stall,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        align_err,
    output logic        ld_timeout,
    output logic [31:0] retired
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    localparam logic [2:0] c_lb  = 3'd0;
    localparam logic [2:0] c_lbu = 3'd1;
    localparam logic [2:0] c_lh  = 3'd2;
    localparam logic [2:0] c_lhu = 3'd3;
    localparam logic [2:0] c_lw  = 3'd4;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_LDWAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [4:0]  r_ld_dst;
    logic        r_ld_wen;
    logic [2:0]  r_ld_type;
    logic [1:0]  r_ld_addr;

    logic [1:0]  w_byte_sel;
    logic [7:0]  w_byte;
    logic        w_half_hi;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic        w_ld_legal;
    logic [7:0]  w_cnt_next;

    // Stall is a pure decode of the state register
    assign wb_stall   = (r_state == S_LDWAIT);
    assign w_cnt_next = r_wait_cnt + 8'd1;

    // Select the addressed byte/halfword lane, extend it and classify legality
    always_comb begin
        w_byte_sel = BIG_ENDIAN ? (2'd3 - r_ld_addr) : r_ld_addr;
        w_half_hi  = BIG_ENDIAN ? ~r_ld_addr[1] : r_ld_addr[1];
        case (w_byte_sel)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half     = w_half_hi ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_ld_data  = dmem_rdata;
        w_ld_legal = 1'b0;
        case (r_ld_type)
            c_lb: begin
                w_ld_data  = {{24{w_byte[7]}}, w_byte};
                w_ld_legal = 1'b1;
            end
            c_lbu: begin
                w_ld_data  = {24'd0, w_byte};
                w_ld_legal = 1'b1;
            end
            c_lh: begin
                w_ld_data  = {{16{w_half[15]}}, w_half};
                w_ld_legal = ~r_ld_addr[0];
            end
            c_lhu: begin
                w_ld_data  = {16'd0, w_half};
                w_ld_legal = ~r_ld_addr[0];
            end
            c_lw: begin
                w_ld_data  = dmem_rdata;
                w_ld_legal = (r_ld_addr == 2'd0);
            end
            default: begin
                w_ld_data  = dmem_rdata;
                w_ld_legal = 1'b0;
            end
        endcase
    end

    // Stage FSM: capture MEM results, wait for load data, commit and count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_ld_dst   <= 5'd0;
            r_ld_wen   <= 1'b0;
            r_ld_type  <= 3'd0;
            r_ld_addr  <= 2'd0;
            rf_wen     <= 1'b0;
            rf_wa      <= 5'd0;
            rf_wd      <= 32'd0;
            align_err  <= 1'b0;
            ld_timeout <= 1'b0;
            retired    <= 32'd0;
        end else begin
            rf_wen    <= 1'b0;
            align_err <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (mem_valid) begin
                        if (!mem_is_load) begin
                            rf_wen  <= mem_wen & (mem_dst != 5'd0);
                            rf_wa   <= mem_dst;
                            rf_wd   <= mem_result;
                            retired <= retired + 32'd1;
                        end else begin
                            r_ld_dst   <= mem_dst;
                            r_ld_wen   <= mem_wen;
                            r_ld_type  <= mem_ld_type;
                            r_ld_addr  <= mem_addr_lo;
                            r_wait_cnt <= 8'd0;
                            r_state    <= S_LDWAIT;
                        end
                    end
                end
                S_LDWAIT: begin
                    // Data arriving on the watchdog's last cycle still commits
                    if (dmem_rvalid) begin
                        r_state <= S_RUN;
                        retired <= retired + 32'd1;
                        if (w_ld_legal) begin
                            rf_wen <= r_ld_wen & (r_ld_dst != 5'd0);
                            rf_wa  <= r_ld_dst;
                            rf_wd  <= w_ld_data;
                        end else begin
                            align_err <= 1'b1;
                        end
                    end else if (w_cnt_next == c_max_wait) begin
                        ld_timeout <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_wait_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_stage                                                  |
// | Description : Self-checking bench for wb_stage. Two instances (big- and    |
// |               little-endian) share stimulus; a transaction-level model     |
// |               predicts every output after each clock edge.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_stage;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_wen, mem_is_load, dmem_rvalid;
    logic [4:0]  mem_dst;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_result, dmem_rdata;

    logic        be_stall, be_wen, be_aerr, be_to;
    logic [4:0]  be_wa;
    logic [31:0] be_wd, be_ret;
    logic        le_stall, le_wen, le_aerr, le_to;
    logic [4:0]  le_wa;
    logic [31:0] le_wd, le_ret;

    int checks = 0;
    int errors = 0;

    // Reference-model state
    logic [4:0]  e_wa;
    logic [31:0] e_wd_be, e_wd_le, e_ret;
    logic        e_to;

    always #5 clk = ~clk;

    wb_stage #(.MAX_WAIT(MW), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_dst(mem_dst), .mem_is_load(mem_is_load), .mem_ld_type(mem_ld_type),
        .mem_addr_lo(mem_addr_lo), .mem_result(mem_result), .wb_stall(be_stall),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_wen(be_wen),
        .rf_wa(be_wa), .rf_wd(be_wd), .align_err(be_aerr), .ld_timeout(be_to),
        .retired(be_ret)
    );

    wb_stage #(.MAX_WAIT(MW), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_dst(mem_dst), .mem_is_load(mem_is_load), .mem_ld_type(mem_ld_type),
        .mem_addr_lo(mem_addr_lo), .mem_result(mem_result), .wb_stall(le_stall),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_wen(le_wen),
        .rf_wa(le_wa), .rf_wd(le_wd), .align_err(le_aerr), .ld_timeout(le_to),
        .retired(le_ret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected load result from the byte-lane rules, using plain arithmetic
    function automatic logic [31:0] ld_value(input int t, input int a, input logic [31:0] w, input bit be);
        int idx;
        logic [31:0] v;
        v = w;
        if (t == 0 || t == 1) begin
            idx = be ? (3 - a) : a;
            v = (w >> (8 * idx)) & 32'h0000_00FF;
            if (t == 0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (t == 2 || t == 3) begin
            idx = be ? (1 - a / 2) : (a / 2);
            v = (w >> (16 * idx)) & 32'h0000_FFFF;
            if (t == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic bit ld_legal(input int t, input int a);
        if (t > 4) return 1'b0;
        if ((t == 2 || t == 3) && (a % 2 != 0)) return 1'b0;
        if (t == 4 && a != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all(input logic ewen, input logic eal, input logic estall);
        check("be.rf_wen", 32'(be_wen), 32'(ewen));
        check("be.rf_wa", 32'(be_wa), 32'(e_wa));
        check("be.rf_wd", be_wd, e_wd_be);
        check("be.retired", be_ret, e_ret);
        check("be.align_err", 32'(be_aerr), 32'(eal));
        check("be.ld_timeout", 32'(be_to), 32'(e_to));
        check("be.wb_stall", 32'(be_stall), 32'(estall));
        check("le.rf_wen", 32'(le_wen), 32'(ewen));
        check("le.rf_wa", 32'(le_wa), 32'(e_wa));
        check("le.rf_wd", le_wd, e_wd_le);
        check("le.retired", le_ret, e_ret);
        check("le.align_err", 32'(le_aerr), 32'(eal));
        check("le.ld_timeout", 32'(le_to), 32'(e_to));
        check("le.wb_stall", 32'(le_stall), 32'(estall));
    endtask

    task automatic model_reset();
        e_wa = 5'd0; e_wd_be = 32'd0; e_wd_le = 32'd0; e_ret = 32'd0; e_to = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_fields();
        mem_wen     = 1'($urandom);
        mem_dst     = 5'($urandom);
        mem_is_load = 1'($urandom);
        mem_ld_type = 3'($urandom);
        mem_addr_lo = 2'($urandom);
        mem_result  = $urandom;
        dmem_rdata  = $urandom;
    endtask

    task automatic run_nonload(input logic [4:0] dst, input logic wen, input logic [31:0] res);
        noise_fields();
        mem_valid = 1'b1; mem_is_load = 1'b0;
        mem_dst = dst; mem_wen = wen; mem_result = res;
        dmem_rvalid = 1'($urandom);
        tick();
        e_wa = dst; e_wd_be = res; e_wd_le = res; e_ret = e_ret + 32'd1;
        check_all(wen && (dst != 5'd0), 1'b0, 1'b0);
    endtask

    task automatic run_idle(input logic rv);
        noise_fields();
        mem_valid = 1'b0;
        dmem_rvalid = rv;
        tick();
        check_all(1'b0, 1'b0, 1'b0);
    endtask

    // lat = stall cycles before rvalid; lat > MW means the data never comes
    task automatic run_load(input int t, input int a, input logic [4:0] dst, input logic wen,
                            input int lat, input logic [31:0] word);
        noise_fields();
        mem_valid = 1'b1; mem_is_load = 1'b1;
        mem_ld_type = 3'(t); mem_addr_lo = 2'(a); mem_dst = dst; mem_wen = wen;
        dmem_rvalid = 1'($urandom);
        tick();
        check_all(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= MW; k++) begin
            noise_fields();
            mem_valid   = 1'($urandom);
            dmem_rvalid = (k == lat);
            if (k == lat) dmem_rdata = word;
            tick();
            if (k == lat) begin
                e_ret = e_ret + 32'd1;
                if (ld_legal(t, a)) begin
                    e_wa = dst;
                    e_wd_be = ld_value(t, a, word, 1'b1);
                    e_wd_le = ld_value(t, a, word, 1'b0);
                    check_all(wen && (dst != 5'd0), 1'b0, 1'b0);
                end else begin
                    check_all(1'b0, 1'b1, 1'b0);
                end
                return;
            end else if (k == MW) begin
                e_to = 1'b1;
                check_all(1'b0, 1'b0, 1'b0);
                return;
            end else begin
                check_all(1'b0, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 1'b0; dmem_rvalid = 1'b0;
        noise_fields();
        model_reset();
        #1;
        check_all(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_all(1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Single non-load write
        run_nonload(5'd5, 1'b1, 32'hDEAD_BEEF);
        check("t1.retired", be_ret, 32'd1);

        // Signed and unsigned byte loads, lane 1
        run_load(0, 1, 5'd7, 1'b1, 3, 32'h12F4_5678);
        check("t2.lb", be_wd, 32'hFFFF_FFF4);
        run_load(1, 1, 5'd7, 1'b1, 3, 32'h12F4_5678);
        check("t2.lbu", be_wd, 32'h0000_00F4);

        // Misaligned halfword, then a legal word load to r0
        run_load(2, 1, 5'd8, 1'b1, 2, 32'h1234_5678);
        run_load(4, 0, 5'd0, 1'b1, 1, 32'hAAAA_5555);

        // Watchdog expiry, then stale rvalid in RUN
        run_load(4, 0, 5'd9, 1'b1, MW + 1, 32'h0);
        run_idle(1'b1);
        run_idle(1'b0);

        // Reset during the second wait cycle of a load
        noise_fields();
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_ld_type = 3'd4; mem_addr_lo = 2'd0;
        dmem_rvalid = 1'b0;
        tick();
        check_all(1'b0, 1'b0, 1'b1);
        mem_valid = 1'b0;
        tick();
        check_all(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all(1'b0, 1'b0, 1'b0);
        tick();
        check_all(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        run_idle(1'b1);

        // Back-to-back writes then a one-cycle load
        run_nonload(5'd1, 1'b1, 32'h1111_1111);
        run_nonload(5'd2, 1'b1, 32'h2222_2222);
        run_nonload(5'd3, 1'b1, 32'h3333_3333);
        run_load(4, 0, 5'd4, 1'b1, 1, 32'hCAFE_F00D);
        check("t6.wd", be_wd, 32'hCAFE_F00D);
        check("t6.retired", be_ret, 32'd4);

        // Randomised instruction mix
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 45)
                run_nonload(5'($urandom), 1'($urandom), $urandom);
            else if (sel < 60)
                run_idle(1'($urandom));
            else
                run_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 5'($urandom),
                         1'($urandom), int'($urandom_range(1, MW + 2)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
